// File: rtl/obj_oam_arbiter.sv
// obj_oam_arbiter: shares the OAM port between affine fetch, OBJ scanner and CPU.
// Optional CPU starvation guard enabled by defining OBJ_OAM_STARVE_GUARD_EN.
module obj_oam_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int BURST_LEN    = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        attr_req,
   input  logic [7:0]  attr_addr,
   output logic        attr_gnt,
   output logic        attr_rvalid,
   input  logic        obj_req,
   input  logic [7:0]  obj_addr,
   output logic        obj_gnt,
   output logic        obj_rvalid,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_be,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   input  logic        forced_blank,
   output logic [31:0] rdata,
   output logic [7:0]  OAM_mem_addr,
   output logic        OAM_mem_we,
   output logic [31:0] OAM_mem_wdata,
   output logic [3:0]  OAM_mem_be,
   input  logic [31:0] OAM_mem_data
);

   localparam int BW = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN + 1);
   localparam logic [1:0] T_ATTR = 2'd0;
   localparam logic [1:0] T_OBJ  = 2'd1;
   localparam logic [1:0] T_CPU  = 2'd2;

   typedef enum logic {S_ARB, S_BURST} state_t;

   state_t        r_state;
   logic [BW-1:0] r_beat;
   logic [7:0]    r_addr;
   logic          r_rv_valid;
   logic [1:0]    r_rv_tag;

   logic          w_starved;
   logic          w_attr_gnt;
   logic          w_obj_gnt;
   logic          w_cpu_gnt;
   logic          w_any_gnt;
   logic [7:0]    w_gnt_addr;
   logic          w_cpu_wr;

`ifdef OBJ_OAM_STARVE_GUARD_EN
   logic [3:0]    r_starve;

   assign w_starved = (r_starve == 4'(STARVE_LIMIT));

   // Count ARB cycles a pending CPU request is refused, saturating
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_starve <= 4'd0;
      end else if (!cpu_req || w_cpu_gnt) begin
         r_starve <= 4'd0;
      end else if (r_state == S_ARB && !w_starved) begin
         r_starve <= r_starve + 4'd1;
      end
   end
`else
   assign w_starved = 1'b0;
`endif

   // Grant selection: burst lock, then CPU-first or attr-first priority
   always_comb begin
      w_attr_gnt = 1'b0;
      w_obj_gnt  = 1'b0;
      w_cpu_gnt  = 1'b0;
      if (reset_n) begin
         if (r_state == S_BURST) begin
            w_attr_gnt = attr_req;
         end else if ((forced_blank || w_starved) && cpu_req) begin
            w_cpu_gnt = 1'b1;
         end else if (attr_req) begin
            w_attr_gnt = 1'b1;
         end else if (obj_req) begin
            w_obj_gnt = 1'b1;
         end else if (cpu_req) begin
            w_cpu_gnt = 1'b1;
         end
      end
   end

   assign w_any_gnt  = w_attr_gnt | w_obj_gnt | w_cpu_gnt;
   assign w_cpu_wr   = w_cpu_gnt & cpu_we;
   assign w_gnt_addr = w_attr_gnt ? attr_addr :
                       w_obj_gnt  ? obj_addr  : cpu_addr;

   assign attr_gnt      = w_attr_gnt;
   assign obj_gnt       = w_obj_gnt;
   assign cpu_gnt       = w_cpu_gnt;
   assign OAM_mem_addr  = w_any_gnt ? w_gnt_addr : r_addr;
   assign OAM_mem_we    = w_cpu_wr;
   assign OAM_mem_wdata = w_cpu_wr ? cpu_wdata : 32'd0;
   assign OAM_mem_be    = w_cpu_wr ? cpu_be : 4'd0;

   assign rdata       = OAM_mem_data;
   assign attr_rvalid = r_rv_valid && (r_rv_tag == T_ATTR);
   assign obj_rvalid  = r_rv_valid && (r_rv_tag == T_OBJ);
   assign cpu_rvalid  = r_rv_valid && (r_rv_tag == T_CPU);

   // Burst lock FSM: enter on an attr grant, leave after the last beat
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_ARB;
         r_beat  <= '0;
      end else begin
         unique case (r_state)
            S_ARB: begin
               if (w_attr_gnt && BURST_LEN > 1) begin
                  r_state <= S_BURST;
                  r_beat  <= BW'(1);
               end
            end
            S_BURST: begin
               if (w_attr_gnt) begin
                  if (r_beat == BW'(BURST_LEN - 1)) begin
                     r_state <= S_ARB;
                     r_beat  <= '0;
                  end else begin
                     r_beat <= r_beat + BW'(1);
                  end
               end
            end
            default: begin
               r_state <= S_ARB;
               r_beat  <= '0;
            end
         endcase
      end
   end

   // Hold last address and tag each read grant for next-cycle rvalid
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_addr     <= 8'd0;
         r_rv_valid <= 1'b0;
         r_rv_tag   <= T_ATTR;
      end else begin
         if (w_any_gnt) begin
            r_addr <= w_gnt_addr;
         end
         r_rv_valid <= w_any_gnt && !w_cpu_wr;
         if (w_attr_gnt) begin
            r_rv_tag <= T_ATTR;
         end else if (w_obj_gnt) begin
            r_rv_tag <= T_OBJ;
         end else if (w_cpu_gnt) begin
            r_rv_tag <= T_CPU;
         end
      end
   end

endmodule
